input_conditioner: RTL and testbench

Front-end conditioning stage for the board inputs that feed the Computer_System parallel-I/O and interrupt ports: pushbuttons, slider switches, touch pen-IRQ and joystick IRQ. The block synchronises each raw pin to the system clock, normalises polarity and debounces it with a per-bit counter. It drives clean levels and edge pulses, and keeps a sticky edge-capture register with a masked, level interrupt output. It sits directly between the FPGA pins and the system's `*_export` inputs, on the same clock as the system PLL output.

---
 rtl/input_conditioner_if.sv | 24 ++
 rtl/input_conditioner.sv | 71 +++++++
 tb/tb_input_conditioner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// Bus bundle between the FPGA pins/CPU-side controls and the input conditioner.
// The master drives raw pins, clear strobes and masks. The slave returns the conditioned state.
interface input_conditioner_if #(
   parameter int unsigned WIDTH = 14
);
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clear_in;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] clean_out;
   logic [WIDTH-1:0] rise_out;
   logic [WIDTH-1:0] fall_out;
   logic [WIDTH-1:0] edge_capture;
   logic             irq_out;

   modport master (
      output raw_in, clear_in, irq_mask,
      input  clean_out, rise_out, fall_out, edge_capture, irq_out
   );

   modport slave (
      input  raw_in, clear_in, irq_mask,
      output clean_out, rise_out, fall_out, edge_capture, irq_out
   );
endinterface

// File: rtl/input_conditioner.sv
// Per-bit synchroniser, polarity normaliser and counter debouncer.
// It also provides edge pulses, a sticky edge capture register and a masked level IRQ.
module input_conditioner #(
   parameter int unsigned      WIDTH           = 14,
   parameter logic [WIDTH-1:0] INVERT_MASK     = 14'b01_0000_0000_0011,
   parameter int unsigned      DEBOUNCE_CYCLES = 500000,
   parameter int unsigned      CNT_WIDTH       = 20
) (
   input logic                clk_clk,
   input logic                reset_reset,
   input_conditioner_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]     s1_q, s2_q;
   logic [WIDTH-1:0]     stable_q, stable_d;
   logic [WIDTH-1:0]     rise_q, rise_d;
   logic [WIDTH-1:0]     fall_q, fall_d;
   logic [WIDTH-1:0]     cap_q, cap_d;
   logic                 irq_q, irq_d;
   logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
   logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0]     c;
   logic [WIDTH-1:0]     accept;

   always_comb begin
      c      = s2_q ^ INVERT_MASK;
      accept = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (c[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) accept[i] = 1'b1;
            else                      cnt_d[i]  = cnt_q[i] + 1'b1;
         end
      end
      stable_d = (stable_q & ~accept) | (c & accept);
      rise_d   = accept & c;
      fall_d   = accept & ~c;
      // Set dominates a simultaneous clear on the same bit.
      cap_d    = (cap_q & ~bus.clear_in) | accept;
      irq_d    = |(cap_q & bus.irq_mask);
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         s1_q     <= INVERT_MASK;
         s2_q     <= INVERT_MASK;
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         cap_q    <= '0;
         irq_q    <= 1'b0;
         for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         s1_q     <= bus.raw_in;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cap_q    <= cap_d;
         irq_q    <= irq_d;
         for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.clean_out    = stable_q;
   assign bus.rise_out     = rise_q;
   assign bus.fall_out     = fall_q;
   assign bus.edge_capture = cap_q;
   assign bus.irq_out      = irq_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce.
// All expected values are hand-derived from the synchroniser and debounce latency.
module tb_input_conditioner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   input_conditioner_if #(.WIDTH(14)) ifc ();

   input_conditioner #(
      .WIDTH          (14),
      .INVERT_MASK    (14'h1003),
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH      (3)
   ) dut (
      .clk_clk    (clk),
      .reset_reset(rst),
      .bus        (ifc)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [63:0] all_out();
      return {7'd0, ifc.clean_out, ifc.rise_out, ifc.fall_out, ifc.edge_capture, ifc.irq_out};
   endfunction

   // Each step() lands on the negedge after one more posedge.
   // A raw change made at a negedge is therefore sampled by the next posedge, which is edge E.
   initial begin
      // All inputs are at their inactive level. Pen-IRQ is active-low, like the buttons.
      ifc.raw_in   = 14'h1003;
      ifc.clear_in = '0;
      ifc.irq_mask = '0;
      step(3);
      check("reset_outputs", all_out(), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("idle_after_reset", all_out(), 64'd0);
      end

      // Button 0 press: raw goes 1 -> 0 and is active-low.
      ifc.irq_mask[0] = 1'b1;
      ifc.raw_in[0]   = 1'b0;
      step(5);                                        // after E+4
      check("btn_clean_early", 64'(ifc.clean_out[0]), 64'd0);
      check("btn_rise_early",  64'(ifc.rise_out[0]),  64'd0);
      step(1);                                        // after E+5
      check("btn_clean",  64'(ifc.clean_out),    64'h0001);
      check("btn_cap",    64'(ifc.edge_capture), 64'h0001);
      check("btn_rise",   64'(ifc.rise_out),     64'h0001);
      check("btn_fall",   64'(ifc.fall_out),     64'h0000);
      check("btn_irq_early", 64'(ifc.irq_out),   64'd0);
      step(1);                                        // after E+6
      check("btn_rise_end", 64'(ifc.rise_out), 64'h0000);
      check("btn_irq",      64'(ifc.irq_out),  64'd1);
      check("btn_clean_hold", 64'(ifc.clean_out), 64'h0001);

      // Clear everything. The IRQ follows the capture register one edge later.
      ifc.clear_in = '1;
      step(1);
      ifc.clear_in = '0;
      check("clr_cap", 64'(ifc.edge_capture), 64'h0);
      check("clr_irq_lag", 64'(ifc.irq_out), 64'd1);
      step(1);
      check("clr_irq", 64'(ifc.irq_out), 64'd0);
      ifc.irq_mask = '0;

      // A 3-cycle glitch on bit 5 must produce no activity.
      ifc.raw_in[5] = 1'b1;
      step(3);
      ifc.raw_in[5] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("glitch3_quiet",
               64'({ifc.clean_out[5], ifc.rise_out[5], ifc.fall_out[5], ifc.edge_capture[5]}), 64'd0);
      end

      // A 4-cycle pulse on bit 5 is accepted.
      ifc.raw_in[5] = 1'b1;
      step(4);
      ifc.raw_in[5] = 1'b0;                           // low level sampled at E+4
      step(1);                                        // after E+4
      check("p4_rise_early", 64'(ifc.rise_out[5]),  64'd0);
      check("p4_clean_early", 64'(ifc.clean_out[5]), 64'd0);
      step(1);                                        // after E+5
      check("p4_rise",  64'(ifc.rise_out),     64'h0020);
      check("p4_clean", 64'(ifc.clean_out),    64'h0021);
      check("p4_cap",   64'(ifc.edge_capture), 64'h0020);
      check("p4_fall_none", 64'(ifc.fall_out), 64'h0);
      step(1);
      check("p4_rise_end", 64'(ifc.rise_out[5]), 64'd0);
      step(2);                                        // after E+8
      check("p4_fall_early", 64'(ifc.fall_out[5]), 64'd0);
      check("p4_clean_hold", 64'(ifc.clean_out[5]), 64'd1);
      step(1);                                        // after E+9
      check("p4_fall",   64'(ifc.fall_out),  64'h0020);
      check("p4_rise_off", 64'(ifc.rise_out), 64'h0);
      check("p4_clean_low", 64'(ifc.clean_out[5]), 64'd0);
      step(1);
      check("p4_fall_end", 64'(ifc.fall_out[5]), 64'd0);
      ifc.clear_in = '1;
      step(1);
      ifc.clear_in = '0;
      step(1);

      // A switch change while masked is captured without raising the IRQ.
      ifc.raw_in[2] = 1'b1;
      step(6);                                        // after E+5
      check("mask_cap",   64'(ifc.edge_capture[2]), 64'd1);
      check("mask_clean", 64'(ifc.clean_out[2]),    64'd1);
      step(1);
      check("mask_irq_off", 64'(ifc.irq_out), 64'd0);
      ifc.irq_mask[2] = 1'b1;
      step(1);
      check("mask_irq_on", 64'(ifc.irq_out), 64'd1);
      ifc.irq_mask = '0;
      ifc.clear_in = '1;
      step(1);
      ifc.clear_in = '0;
      step(1);
      check("mask_cleanup", 64'({ifc.edge_capture, ifc.irq_out}), 64'd0);

      // A clear that collides with an accept on bit 13 loses to the set.
      ifc.irq_mask[13] = 1'b1;
      ifc.raw_in[13]   = 1'b1;
      step(5);                                        // after E+4, accept is pending
      ifc.clear_in[13] = 1'b1;
      step(1);                                        // after E+5
      check("coll_cap",   64'(ifc.edge_capture[13]), 64'd1);
      check("coll_clean", 64'(ifc.clean_out[13]),    64'd1);
      step(1);                                        // after E+6
      ifc.clear_in = '0;
      check("coll_cleared", 64'(ifc.edge_capture[13]), 64'd0);
      check("coll_irq_on",  64'(ifc.irq_out),          64'd1);
      step(1);
      check("coll_irq_off", 64'(ifc.irq_out), 64'd0);

      // Reset in the middle of a pen-IRQ count discards that count.
      ifc.raw_in[12] = 1'b0;
      step(4);                                        // after E+3: count is 2
      rst = 1'b1;
      #1;
      check("midrst_outputs", all_out(), 64'd0);
      step(1);
      rst = 1'b0;
      step(5);                                        // after release edge +4
      check("midrst_clean_early", 64'(ifc.clean_out[12]), 64'd0);
      step(1);                                        // after release edge +5
      check("midrst_clean", 64'(ifc.clean_out[12]), 64'd1);
      check("midrst_rise",  64'(ifc.rise_out[12]),  64'd1);
      check("midrst_cap",   64'(ifc.edge_capture[12]), 64'd1);
      step(1);
      check("midrst_rise_end", 64'(ifc.rise_out[12]), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
